dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Responder end of the data-memory interface.
//  Requesters are the pipeline Memory stage and the matmul engine; an upstream mux presents one requester at a time.
//  Word-organised RAM with a valid/ready request channel and a valid/ready response channel.
//  Fixed, parameterised read latency, byte-enable writes and an in-order error response.
//  One response per accepted request; no request or response is ever dropped.
// PARAMETERS
//  DEPTH      1024          number of 32-bit words
//  ADDR_BASE  32'h0000_0000 byte address of word 0
//  RD_LATENCY 1             accept-to-response cycles, legal range 1..4
//  FIFO_DEPTH RD_LATENCY+2  response buffer entries; also the outstanding-request credit limit
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   asynchronous, active-low reset
//  req_valid    in   1   request present
//  req_ready    out  1   request accepted this cycle if req_valid
//  req_we       in   1   1 = write, 0 = read
//  req_be       in   4   write byte lanes; [0] = bits 7:0; ignored on reads
//  req_addr     in   32  byte address
//  req_wdata    in   32  write data
//  rsp_valid    out  1   response present
//  rsp_ready    in   1   consumer takes the response
//  rsp_rdata    out  32  read data; 0 for writes and errors
//  rsp_err      out  1   misaligned or out-of-range request
//  rsp_we       out  1   echoes req_we of the request being answered
//  outstanding  out  $clog2(FIFO_DEPTH+1)  requests accepted but not yet answered
// BEHAVIOUR
//  Reset (async assert, sync release) forces:
//   - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_we=0, outstanding=0.
//   - All in-flight and buffered responses are discarded.
//   - RAM contents are not reset.
//  Handshake and credit:
//   - Accept = req_valid & req_ready. Response = rsp_valid & rsp_ready.
//   - req_ready = (outstanding < FIFO_DEPTH), computed from registered state only.
//   - outstanding +1 on accept, -1 on response, unchanged when both occur in the same cycle.
//  Address decode, at accept:
//   - idx = (req_addr - ADDR_BASE) >> 2.
//   - err = (req_addr[1:0] != 0) | (req_addr < ADDR_BASE) | (idx >= DEPTH).
//  Write, no error: at the accept edge, byte lane k is updated iff req_be[k]=1.
//  Write with be=4'b0000: legal; RAM unchanged; response still returned.
//  Read: returns RAM contents as of the accept edge. A read accepted the cycle after a write to the same word returns the new data.
//  Error requests:
//   - RAM is never modified.
//   - rsp_rdata = 0, rsp_err = 1.
//  Latency and buffering:
//   - The response tag {rdata, err, we} traverses a RD_LATENCY-stage shift pipeline.
//   - It then enters a first-word-fall-through FIFO of FIFO_DEPTH entries with wrap-around pointers.
//   - For a request accepted at edge N with the FIFO empty, rsp_valid is high in the cycle following edge N+RD_LATENCY-1, i.e. RD_LATENCY cycles after accept.
//   - Throughput is 1 request per cycle sustained while rsp_ready=1.
//  Response ordering and stability:
//   - Responses are strictly in acceptance order.
//   - rsp_rdata, rsp_err and rsp_we are held stable while rsp_valid & ~rsp_ready.
//  FIFO full:
//   - The credit limit guarantees the FIFO never overflows.
//   - A push and a pop in the same cycle while full is legal.
//  FIFO empty: rsp_valid=0 and outputs are held at their last values. Pop is never issued while empty.
//  Reset mid-operation: behaves as reset; nothing emerges afterwards from pre-reset requests.
// TESTING
//  T1 RD_LATENCY=1: write 0xDEADBEEF, be=F, @0x10; then read @0x10.
//     -> rsp_rdata=0xDEADBEEF, err=0, rsp_valid exactly 1 cycle after the read is accepted.
//  T2 Write 0x11223344, be=F, @0x20; write 0xAABBCCDD, be=4'b0101, @0x20; read @0x20.
//     -> rsp_rdata=0x11BB33DD.
//  T3 Read @0x13 -> err=1, rdata=0.
//     Write 0x5 @DEPTH*4 -> err=1, rsp_we=1; a following read @0x0 is unchanged.
//  T4 Hold rsp_ready=0 and stream reads @0x0,0x4,...
//     -> req_ready falls after FIFO_DEPTH accepts; outputs stable.
//     Release rsp_ready -> all FIFO_DEPTH responses in order, none lost.
//  T5 Stream 64 reads with rsp_ready=1 at RD_LATENCY=3.
//     -> one accept and one response per cycle; outstanding constant at 3 once filled.
//     Simultaneous accept and response leave it unchanged.
//  T6 Three reads in flight, assert reset mid-cycle.
//     -> rsp_valid=0 immediately; after release outstanding=0, req_ready=1, no stale rsp_valid for 10 cycles.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Request/response channel bundle between a data-memory requester and dmem_responder.
// The master side issues requests and consumes responses; the slave side answers them.
interface dmem_responder_if #(
    parameter int unsigned FIFO_DEPTH = 3
);
    localparam int unsigned OW = $clog2(FIFO_DEPTH + 1);

    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [3:0]    req_be;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          rsp_we;
    logic [OW-1:0] outstanding;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_we, outstanding
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_we, outstanding
    );
endinterface

// File: rtl/dmem_responder.sv
// Word RAM answering valid/ready requests in order after a fixed latency.
// Response tags ride a shift pipe into an FWFT FIFO; credits cap in-flight requests at FIFO_DEPTH.
module dmem_responder #(
    parameter int unsigned DEPTH      = 1024,
    parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned FIFO_DEPTH = RD_LATENCY + 2
) (
    input logic             clk,
    input logic             reset,
    dmem_responder_if.slave bus
);
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        we;
    } tag_t;

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned OW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]   ram [DEPTH];
    tag_t          fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [OW-1:0] cnt_q, cnt_d, out_q, out_d;
    tag_t          last_q, head, acc_tag, push_tag;
    logic          req_ready, acc, pop, push, err;
    logic [29:0]   widx;
    logic [AW-1:0] idx;

    assign req_ready = out_q < OW'(FIFO_DEPTH);
    assign acc       = bus.req_valid & req_ready;
    assign pop       = (cnt_q != '0) & bus.rsp_ready;

    assign widx = 30'((bus.req_addr - ADDR_BASE) >> 2);
    assign idx  = widx[AW-1:0];
    assign err  = (bus.req_addr[1:0] != 2'b00) | (bus.req_addr < ADDR_BASE)
                | (32'(widx) >= 32'(DEPTH));

    // Read sees the array before this edge's write, so a read one cycle after a write sees it.
    always_comb begin
        acc_tag.rdata = (bus.req_we | err) ? 32'h0 : ram[idx];
        acc_tag.err   = err;
        acc_tag.we    = bus.req_we;
    end

    always_ff @(posedge clk) begin
        if (acc & bus.req_we & ~err) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.req_be[k]) ram[idx][8*k +: 8] <= bus.req_wdata[8*k +: 8];
            end
        end
    end

    // The FIFO write is the final latency stage, so only RD_LATENCY-1 pipe registers exist.
    generate
        if (RD_LATENCY == 1) begin : g_nopipe
            assign push     = acc;
            assign push_tag = acc_tag;
        end else begin : g_pipe
            logic [RD_LATENCY-2:0] vld_pipe;
            tag_t                  tag_pipe [RD_LATENCY-1];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    vld_pipe <= '0;
                    for (int k = 0; k < RD_LATENCY - 1; k++) tag_pipe[k] <= '0;
                end else begin
                    vld_pipe[0] <= acc;
                    tag_pipe[0] <= acc_tag;
                    for (int k = 1; k < RD_LATENCY - 1; k++) begin
                        vld_pipe[k] <= vld_pipe[k-1];
                        tag_pipe[k] <= tag_pipe[k-1];
                    end
                end
            end

            assign push     = vld_pipe[RD_LATENCY-2];
            assign push_tag = tag_pipe[RD_LATENCY-2];
        end
    endgenerate

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        out_d = out_q + OW'(acc) - OW'(pop);
        cnt_d = cnt_q + OW'(push) - OW'(pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q  <= '0;
            cnt_q  <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            last_q <= '0;
        end else begin
            out_q <= out_d;
            cnt_q <= cnt_d;
            if (push) wr_q <= wrap_inc(wr_q);
            if (pop) begin
                rd_q   <= wrap_inc(rd_q);
                last_q <= fifo_q[rd_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_q] <= push_tag;
    end

    // When empty the last popped response stays on the outputs.
    assign head = (cnt_q != '0) ? fifo_q[rd_q] : last_q;

    assign bus.req_ready   = req_ready;
    assign bus.rsp_valid   = (cnt_q != '0);
    assign bus.rsp_rdata   = head.rdata;
    assign bus.rsp_err     = head.err;
    assign bus.rsp_we      = head.we;
    assign bus.outstanding = out_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed checks of dmem_responder at RD_LATENCY=1 (u_dut1) and RD_LATENCY=3 (u_dut3).
// Inputs change on the falling edge; outputs are sampled there too.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    dmem_responder_if #(.FIFO_DEPTH(3)) b1 ();
    dmem_responder_if #(.FIFO_DEPTH(5)) b3 ();

    dmem_responder #(.RD_LATENCY(1)) u_dut1 (.clk(clk), .reset(reset), .bus(b1));
    dmem_responder #(.RD_LATENCY(3)) u_dut3 (.clk(clk), .reset(reset), .bus(b3));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One request on u_dut1 with rsp_ready high; returns the response and its latency in cycles.
    task automatic xact(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd, output logic err,
                        output logic rwe, output int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (!b1.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        b1.req_valid = 1'b1;
        b1.req_we    = we;
        b1.req_be    = be;
        b1.req_addr  = addr;
        b1.req_wdata = wdata;
        @(negedge clk);
        b1.req_valid = 1'b0;
        lat = 1;
        while (!b1.rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd  = b1.rsp_rdata;
        err = b1.rsp_err;
        rwe = b1.rsp_we;
    endtask

    function automatic logic [31:0] pat(input int i);
        logic [31:0] v;
        v = 32'h0101_0101 * i;
        return v ^ 32'hA5A5_0000;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er, rwe;
        int          lat;
        logic [31:0] exp4 [3];
        int          nr;

        b1.req_valid = 0; b1.req_we = 0; b1.req_be = 0; b1.req_addr = 0; b1.req_wdata = 0;
        b1.rsp_ready = 1;
        b3.req_valid = 0; b3.req_we = 0; b3.req_be = 0; b3.req_addr = 0; b3.req_wdata = 0;
        b3.rsp_ready = 1;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(b1.req_ready), 1);
        chk("rst_valid", 32'(b1.rsp_valid), 0);
        chk("rst_rdata", b1.rsp_rdata, 0);
        chk("rst_err",   32'(b1.rsp_err), 0);
        chk("rst_we",    32'(b1.rsp_we), 0);
        chk("rst_out",   32'(b1.outstanding), 0);
        chk("rst3_valid", 32'(b3.rsp_valid), 0);
        chk("rst3_out",  32'(b3.outstanding), 0);
        reset = 1'b1;

        // T1
        xact(1, 4'hF, 32'h10, 32'hDEAD_BEEF, rd, er, rwe, lat);
        chk("t1_wr_rdata", rd, 0);
        chk("t1_wr_err", 32'(er), 0);
        chk("t1_wr_we", 32'(rwe), 1);
        chk("t1_wr_lat", 32'(lat), 1);
        xact(0, 4'h0, 32'h10, 32'h0, rd, er, rwe, lat);
        chk("t1_rd_rdata", rd, 32'hDEAD_BEEF);
        chk("t1_rd_err", 32'(er), 0);
        chk("t1_rd_lat", 32'(lat), 1);

        // T2 byte enables
        xact(1, 4'hF, 32'h20, 32'h1122_3344, rd, er, rwe, lat);
        xact(1, 4'b0101, 32'h20, 32'hAABB_CCDD, rd, er, rwe, lat);
        xact(0, 4'h0, 32'h20, 32'h0, rd, er, rwe, lat);
        chk("t2_rdata", rd, 32'h11BB_33DD);

        // T3 errors and empty byte-enable write
        xact(1, 4'hF, 32'h0, 32'hCAFE_F00D, rd, er, rwe, lat);
        xact(0, 4'h0, 32'h13, 32'h0, rd, er, rwe, lat);
        chk("t3_mis_err", 32'(er), 1);
        chk("t3_mis_rdata", rd, 0);
        chk("t3_mis_we", 32'(rwe), 0);
        xact(1, 4'hF, 32'h1000, 32'h5, rd, er, rwe, lat);
        chk("t3_oor_err", 32'(er), 1);
        chk("t3_oor_we", 32'(rwe), 1);
        chk("t3_oor_rdata", rd, 0);
        chk("t3_oor_lat", 32'(lat), 1);
        xact(1, 4'h0, 32'h0, 32'hFFFF_FFFF, rd, er, rwe, lat);
        chk("t3_be0_err", 32'(er), 0);
        chk("t3_be0_we", 32'(rwe), 1);
        xact(0, 4'h0, 32'h0, 32'h0, rd, er, rwe, lat);
        chk("t3_rd0", rd, 32'hCAFE_F00D);

        // read accepted the cycle right after a write to the same word
        @(negedge clk);
        b1.req_valid = 1; b1.req_we = 1; b1.req_be = 4'hF; b1.req_addr = 32'h30;
        b1.req_wdata = 32'h1234_5678;
        @(negedge clk);
        chk("raw_wr_valid", 32'(b1.rsp_valid), 1);
        chk("raw_wr_we", 32'(b1.rsp_we), 1);
        b1.req_we = 0;
        @(negedge clk);
        b1.req_valid = 0;
        chk("raw_rd_valid", 32'(b1.rsp_valid), 1);
        chk("raw_rd_rdata", b1.rsp_rdata, 32'h1234_5678);

        // T4 backpressure fills the FIFO and stops acceptance
        xact(1, 4'hF, 32'h4, 32'h4444_4444, rd, er, rwe, lat);
        xact(1, 4'hF, 32'h8, 32'h8888_8888, rd, er, rwe, lat);
        exp4[0] = 32'hCAFE_F00D; exp4[1] = 32'h4444_4444; exp4[2] = 32'h8888_8888;
        @(negedge clk);
        b1.rsp_ready = 0;
        for (int n = 0; n < 3; n++) begin
            chk("t4_ready", 32'(b1.req_ready), 1);
            b1.req_valid = 1; b1.req_we = 0; b1.req_addr = 32'(4 * n);
            @(negedge clk);
        end
        b1.req_addr = 32'hC;
        chk("t4_full_ready", 32'(b1.req_ready), 0);
        chk("t4_full_out", 32'(b1.outstanding), 3);
        for (int h = 0; h < 3; h++) begin
            chk("t4_hold_valid", 32'(b1.rsp_valid), 1);
            chk("t4_hold_rdata", b1.rsp_rdata, 32'hCAFE_F00D);
            chk("t4_hold_err", 32'(b1.rsp_err), 0);
            @(negedge clk);
        end
        b1.req_valid = 0;
        b1.rsp_ready = 1;
        for (int e = 0; e < 3; e++) begin
            chk("t4_drain_valid", 32'(b1.rsp_valid), 1);
            chk("t4_drain_rdata", b1.rsp_rdata, exp4[e]);
            @(negedge clk);
        end
        chk("t4_empty_valid", 32'(b1.rsp_valid), 0);
        chk("t4_empty_out", 32'(b1.outstanding), 0);
        chk("t4_empty_hold", b1.rsp_rdata, 32'h8888_8888);

        // T5 sustained streaming at RD_LATENCY=3: 64 writes then 64 reads back to back
        nr = 0;
        @(negedge clk);
        for (int c = 0; c < 140; c++) begin
            if (c < 128) chk("t5_ready", 32'(b3.req_ready), 1);
            if (c >= 3 && c <= 128) chk("t5_out", 32'(b3.outstanding), 3);
            chk("t5_valid", 32'(b3.rsp_valid), 32'(c >= 3 && c <= 130));
            if (b3.rsp_valid && nr < 128) begin
                chk("t5_rdata", b3.rsp_rdata, (nr < 64) ? 32'h0 : pat(nr - 64));
                chk("t5_we", 32'(b3.rsp_we), 32'(nr < 64));
                nr++;
            end
            if (c < 128) begin
                b3.req_valid = 1;
                b3.req_we    = (c < 64);
                b3.req_be    = 4'hF;
                b3.req_addr  = 32'(4 * (c % 64));
                b3.req_wdata = pat(c % 64);
            end else begin
                b3.req_valid = 0;
            end
            @(negedge clk);
        end
        chk("t5_count", 32'(nr), 128);
        chk("t5_final_out", 32'(b3.outstanding), 0);

        // T6 reset with three reads in flight
        b1.rsp_ready = 0;
        for (int n = 0; n < 3; n++) begin
            b1.req_valid = 1; b1.req_we = 0; b1.req_addr = 32'(4 * n);
            @(negedge clk);
        end
        b1.req_valid = 0;
        chk("t6_pre_out", 32'(b1.outstanding), 3);
        #2 reset = 1'b0;
        #1;
        chk("t6_async_valid", 32'(b1.rsp_valid), 0);
        chk("t6_async_out", 32'(b1.outstanding), 0);
        chk("t6_async_ready", 32'(b1.req_ready), 1);
        chk("t6_async_rdata", b1.rsp_rdata, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        b1.rsp_ready = 1;
        for (int q = 0; q < 10; q++) begin
            @(negedge clk);
            chk("t6_no_stale", 32'(b1.rsp_valid), 0);
        end
        chk("t6_out", 32'(b1.outstanding), 0);
        chk("t6_ready", 32'(b1.req_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
